// File: rtl/seg_pkg.sv
// Segment-code constants and polarity definitions for the 7-segment scan decoder.
// Build option SEG_SCAN_DECODER_BCD_ONLY_EN is handled in seg7_to_nibble.
package seg_pkg;

   localparam logic SEG_ON = 1'b0;
   localparam logic ANO_ON = 1'b0;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   localparam logic [15:0][6:0] SEG_TABLE = {
      SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
      SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_DONE
   } scan_state_t;

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational 7-segment pattern to hex nibble lookup.
// SEG_SCAN_DECODER_BCD_ONLY_EN restricts accepted codes to 0-9.
module seg7_to_nibble
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nib,
   output logic       hit
);

`ifdef SEG_SCAN_DECODER_BCD_ONLY_EN
   localparam int N_CODES = 10;
`else
   localparam int N_CODES = 16;
`endif

   always_comb begin
      nib = '0;
      hit = 1'b0;
      for (int i = 0; i < N_CODES; i++) begin
         if (seg == SEG_TABLE[i]) begin
            nib = 4'(i);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed common-anode 7-segment bus and rebuilds the digits.
// Optional BCD-only decoding via SEG_SCAN_DECODER_BCD_ONLY_EN.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int P_DIGITS = 4,
   parameter int P_SETTLE = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [P_DIGITS-1:0]   ano,
   input  logic [7:0]            cat,
   output logic [4*P_DIGITS-1:0] digits,
   output logic [P_DIGITS-1:0]   dp,
   output logic [P_DIGITS-1:0]   valid,
   output logic                  frame_stb,
   output logic                  err_stb
);

   logic [P_DIGITS-1:0] ano_q;
   logic [7:0]          cat_q;
   logic [P_DIGITS-1:0] seen_q;
   logic [P_DIGITS-1:0] seen_nxt;
   logic [P_DIGITS-1:0] sel;
   logic [3:0]          cnt_q, cnt_d;
   scan_state_t         state_q, state_d;
   logic                change;
   logic                eval;
   logic [3:0]          nib;
   logic                hit;
   logic                blank;
   logic                single;

   assign change   = (ano != ano_q) || (cat != cat_q);
   assign sel      = (ANO_ON == 1'b0) ? ~ano_q : ano_q;
   assign blank    = ~|sel;
   assign single   = $onehot(sel);
   assign seen_nxt = seen_q | sel;

   seg7_to_nibble u_dec (
      .seg (cat_q[6:0]),
      .nib (nib),
      .hit (hit)
   );

   // A dwell is evaluated once, after P_SETTLE quiet edges.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      eval    = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (change) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
         end
         S_SETTLE: begin
            if (change) begin
               cnt_d = '0;
            end else if (cnt_q == 4'(P_SETTLE - 1)) begin
               eval    = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ano_q     <= '1;
         cat_q     <= {1'b1, SEG_BLANK};
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         seen_q    <= '0;
         digits    <= '0;
         dp        <= '0;
         valid     <= '0;
         frame_stb <= 1'b0;
         err_stb   <= 1'b0;
      end else begin
         ano_q     <= ano;
         cat_q     <= cat;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         frame_stb <= 1'b0;
         err_stb   <= 1'b0;
         if (eval && !blank) begin
            if (single && hit) begin
               for (int i = 0; i < P_DIGITS; i++) begin
                  if (sel[i]) begin
                     digits[4*i +: 4] <= nib;
                     dp[i]            <= (cat_q[7] == SEG_ON);
                     valid[i]         <= 1'b1;
                  end
               end
               if (&seen_nxt) begin
                  frame_stb <= 1'b1;
                  seen_q    <= '0;
               end else begin
                  seen_q <= seen_nxt;
               end
            end else begin
               err_stb <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized self-checking bench for seg_scan_decoder.
// Reference model tracks run lengths of the bus value and decodes by table search.
module tb_seg_scan_decoder;

   localparam int P_DIGITS = 4;
   localparam int P_SETTLE = 2;

`ifdef SEG_SCAN_DECODER_BCD_ONLY_EN
   localparam int N_OK = 10;
`else
   localparam int N_OK = 16;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  ano;
   logic [7:0]  cat;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  valid;
   logic        frame_stb;
   logic        err_stb;

   seg_scan_decoder #(
      .P_DIGITS (P_DIGITS),
      .P_SETTLE (P_SETTLE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ano       (ano),
      .cat       (cat),
      .digits    (digits),
      .dp        (dp),
      .valid     (valid),
      .frame_stb (frame_stb),
      .err_stb   (err_stb)
   );

   always #5 clk = ~clk;

   logic [6:0] codes [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] m_digits;
   logic [3:0]  m_dp, m_valid, m_seen;
   logic [3:0]  prev_ano;
   logic [7:0]  prev_cat;
   int          run;
   logic        m_frame, m_err;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_digits = '0;
      m_dp     = '0;
      m_valid  = '0;
      m_seen   = '0;
      prev_ano = '1;
      prev_cat = '1;
      run      = 0;
   endtask

   // Evaluate one stable dwell using the bus value held in it.
   task automatic model_eval(input logic [3:0] a, input logic [7:0] c);
      int zeros, idx, val;
      zeros = 0;
      idx   = 0;
      val   = -1;
      for (int i = 0; i < 4; i++)
         if (!a[i]) begin
            zeros++;
            idx = i;
         end
      if (zeros == 0) return;
      if (zeros > 1) begin
         m_err = 1'b1;
         return;
      end
      for (int k = 0; k < N_OK; k++)
         if (codes[k] == c[6:0]) val = k;
      if (val < 0) begin
         m_err = 1'b1;
         return;
      end
      m_digits[4*idx +: 4] = 4'(val);
      m_dp[idx]    = ~c[7];
      m_valid[idx] = 1'b1;
      m_seen[idx]  = 1'b1;
      if (m_seen == 4'hF) begin
         m_frame = 1'b1;
         m_seen  = '0;
      end
   endtask

   task automatic step(input logic [3:0] a, input logic [7:0] c,
                       input logic r);
      @(negedge clk);
      ano = a;
      cat = c;
      rst = r;
      @(posedge clk);
      m_frame = 1'b0;
      m_err   = 1'b0;
      if (r) begin
         model_reset();
      end else begin
         if (a != prev_ano || c != prev_cat) begin
            run = 1;
         end else if (run > 0 && run <= P_SETTLE) begin
            run++;
            if (run == P_SETTLE + 1) model_eval(a, c);
         end
         prev_ano = a;
         prev_cat = c;
      end
      #1;
      chk("digits", 32'(digits), 32'(m_digits));
      chk("dp", 32'(dp), 32'(m_dp));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("frame_stb", 32'(frame_stb), 32'(m_frame));
      chk("err_stb", 32'(err_stb), 32'(m_err));
   endtask

   task automatic dwell(input logic [3:0] a, input logic [7:0] c, input int n);
      for (int i = 0; i < n; i++) step(a, c, 1'b0);
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      ano = '1;
      cat = '1;
      model_reset();

      for (int i = 0; i < 3; i++)
         step(4'($urandom), 8'($urandom), 1'b1);
      chk("reset_digits", 32'(digits), 32'h0);
      dwell(4'b1111, 8'hFF, 5);

      dwell(4'b1110, 8'hB0, 3);
      chk("single_d0", 32'(digits[3:0]), 32'h3);
      chk("single_valid", 32'(valid), 32'h1);
      dwell(4'b1110, 8'hB0, 50);

      for (int s = 0; s < 2; s++) begin
         dwell(4'b1110, 8'h80, 3);
         dwell(4'b1101, 8'h90, 3);
         dwell(4'b1011, 8'h79, 3);
         dwell(4'b0111, 8'hC0, 3);
         chk("frame_digits", 32'(digits), 32'h0198);
         chk("frame_dp", 32'(dp), 32'b0100);
      end

      for (int k = 0; k < 10; k++)
         step(4'b1101, {1'b1, 7'(k * 13 + 5)}, 1'b0);
      dwell(4'b1101, 8'hA4, P_SETTLE + 1);
      chk("glitch_d1", 32'(digits[7:4]), 32'h2);

      dwell(4'b1100, 8'hC0, 4);
      dwell(4'b1110, 8'hFF, 4);

      dwell(4'b0111, 8'h88, 4);

      step(4'b1110, 8'hA4, 1'b0);
      step(4'b1110, 8'hA4, 1'b1);
      dwell(4'b1111, 8'hFF, 4);
      chk("midreset_valid", 32'(valid), 32'h0);

      for (int t = 0; t < 300; t++) begin
         logic [3:0] a;
         logic [7:0] c;
         int kind, i, j;
         kind = int'($urandom_range(0, 19));
         if (kind == 0) begin
            step(4'($urandom), 8'($urandom), 1'b1);
            continue;
         end
         i = int'($urandom_range(0, 3));
         j = (i + int'($urandom_range(1, 3))) % 4;
         if (kind < 15)      a = ~(4'b1 << i);
         else if (kind < 17) a = 4'b1111;
         else                a = ~((4'b1 << i) | (4'b1 << j));
         if ($urandom_range(0, 3) != 0)
            c = {1'($urandom), codes[$urandom_range(0, 15)]};
         else
            c = 8'($urandom);
         dwell(a, c, int'($urandom_range(1, 5)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reads a multiplexed common-anode 7-segment bus and rebuilds the displayed digits as packed nibbles.
- The bus is the active-low anode select plus active-low PGFEDCBA cathodes.
- Sits beside the display driver on the same clock, for loopback self-check and scan monitoring.
- Emits per-digit values, decimal-point bits, a frame-complete strobe and an error strobe for illegal patterns.

Parameters:
- P_DIGITS, 4, number of multiplexed digits (anode width).
- P_SETTLE, 2, consecutive stable cycles required before a dwell is captured. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- ano  in  P_DIGITS  anode select, active-low; exactly one low bit selects a digit.
- cat  in  8  cathodes, active-low; bit7=P (dp), bits6..0=GFEDCBA.
- digits  out  4*P_DIGITS  decoded value; digit i in bits [4i+3:4i].
- dp  out  P_DIGITS  decimal point per digit, 1 = lit.
- valid  out  P_DIGITS  digit i captured at least once since reset.
- frame_stb  out  1  one-cycle pulse when every digit has been captured since the last pulse.
- err_stb  out  1  one-cycle pulse for an illegal dwell.

Behaviour:
- Reset: all outputs 0. Internal ano_q, cat_q = all ones. seen mask = 0. settle count = 0. FSM = IDLE.
- Input stage: ano_q and cat_q register ano and cat every cycle. Change = (ano,cat) != (ano_q,cat_q).
- FSM states:
  - IDLE: entered after reset. Any change -> SETTLE, cnt=0.
  - SETTLE: change -> cnt=0, stay in SETTLE. No change -> cnt+1. No change with cnt==P_SETTLE-1 -> evaluate the dwell, go to DONE.
  - DONE: hold, with no further evaluation of the same dwell. Change -> SETTLE, cnt=0.
- Timing: new values first seen on edge E (change detected). The dwell is evaluated on edge E+P_SETTLE, and outputs are visible after that edge.
- Evaluation of ano_q:
  - All ones (blank): ignored. No write, no error.
  - Exactly one low bit i:
    - Decode cat_q[6:0] through the 16-entry table, codes in hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E.
    - Hit: write digits slot i, dp[i]=~cat_q[7], valid[i]=1, seen[i]=1.
    - Miss: err_stb=1 on the next cycle; the slot is left unchanged.
  - More than one low bit: err_stb=1 on the next cycle, no write.
- frame_stb:
  - When a hit makes seen all ones, frame_stb=1 on the following cycle and seen clears to 0 in that same cycle.
  - Repeat captures of an already-seen digit do not advance the frame.
  - Any scan order is accepted.
- Simultaneous events: rst dominates all. A change on the evaluation edge cancels the evaluation (the dwell was unstable).
- Reset mid-dwell abandons the capture. Outputs return to 0.
- The bus may stay frozen on one digit indefinitely. It is captured exactly once per dwell and produces no repeated strobes.

Optional Feature:
- Macro: SEG_SCAN_DECODER_BCD_ONLY_EN.
- Defined: codes A–F count as misses (err_stb pulse, no write).
- Undefined: all 16 codes are accepted.

Decomposition:
- Package seg_pkg holds:
  - the 16 segment-code constants;
  - the active-low polarity constants;
  - the blank pattern (7F).
- One sub-module, seg7_to_nibble: combinational, cat[6:0] in, nibble plus hit out. Both the table and the BCD-only gating live there.
- Top level holds the input registers, FSM, settle counter, slot registers and seen mask.

Test Plan:
- Reset check: assert rst 3 cycles with random ano/cat -> digits=0, dp=0, valid=0, no strobes. Then ano=1111 -> no activity.
- Single dwell, P_SETTLE=2: drive ano=1110, cat=0x30 from edge E -> digits[3:0]=3 and valid=0001 after edge E+2; no err_stb; held 50 cycles with no further strobes.
- Full frame: scan digits 0..3 with codes 0x00, 0x10, 0x79, 0x40 and dp lit on digit 2 (cat=0x79) -> digits=0x0198, dp=0100, one frame_stb after the digit-3 capture. A second identical scan gives a second single pulse.
- Glitch rejection: change cat every cycle for 10 cycles on ano=1101 -> no write. Then hold 0x24 -> digits[7:4]=2 exactly P_SETTLE edges after the last change.
- Illegal patterns: ano=1100 with cat=0x40 -> one err_stb pulse, no write. ano=1110 with cat=0x7F -> one err_stb pulse, slot unchanged.
- Macro and reset: ano=0111 with cat=0x08 -> digits[15:12]=A without the macro; err_stb and no write with SEG_SCAN_DECODER_BCD_ONLY_EN defined. Assert rst at evaluation edge minus 1 -> no capture, outputs 0.
